// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: control-bit positions
// and MEM-stage handshake states.
package riscv_pkg;

  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_WB_PC4    = 3;
  localparam int CTRL_REG_WRITE = 4;

  localparam int CTRL_WB_W = 3;

  typedef enum logic {
    MS_IDLE,
    MS_WAIT
  } mem_state_t;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack sequencer with bounded wait.
// Drives request, pipeline stall and completion strobes.
module dmem_handshake
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic ack,
  output logic dmem_req,
  output logic stall,
  output logic done,
  output logic timed_out
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_c, stall_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (start) begin
          req_c = 1'b1;
          if (ack) begin
            done = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = MS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      MS_WAIT: begin
        req_c = 1'b1;
        if (ack) begin
          done    = 1'b1;
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = MS_IDLE;
          cnt_d     = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Held low while in reset so an abandoned access drops at once.
  assign dmem_req = req_c & reset_n;
  assign stall    = stall_c & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: word load/store over req/ack,
// misalignment and timeout flags, MEM/WB register.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           ctrl_mem,
  input  logic [31:0]          rd_mem,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          write_data1,
  input  logic [31:0]          pc4_mem,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 stall,
  output logic [CTRL_WB_W-1:0] ctrl_wb,
  output logic [4:0]           rd_wb,
  output logic [31:0]          read_data,
  output logic [31:0]          alu_result_wb,
  output logic [31:0]          pc4_wb,
  output logic                 misaligned,
  output logic                 timeout_err
);

  logic mem_op, misal, start;
  logic done, timed_out;

  logic [CTRL_WB_W-1:0] ctrl_wb_q, ctrl_wb_d;
  logic [4:0]           rd_wb_q, rd_wb_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          alu_wb_q, alu_wb_d;
  logic [31:0]          pc4_wb_q, pc4_wb_d;
  logic                 misal_q, misal_d;
  logic                 tout_q, tout_d;

  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_mem[31:5];

  assign mem_op = ctrl_mem[CTRL_MEM_READ] | ctrl_mem[CTRL_MEM_WRITE];
  assign misal  = mem_op & (alu_result[1:0] != 2'b00);
  assign start  = mem_op & ~misal;

  // A store wins when both read and write are decoded.
  assign dmem_we    = ctrl_mem[CTRL_MEM_WRITE];
  assign dmem_addr  = alu_result;
  assign dmem_wdata = write_data1;

  dmem_handshake #(
    .TIMEOUT(TIMEOUT)
  ) u_hs (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .ack      (dmem_ack),
    .dmem_req (dmem_req),
    .stall    (stall),
    .done     (done),
    .timed_out(timed_out)
  );

  always_comb begin
    ctrl_wb_d = ctrl_wb_q;
    rd_wb_d   = rd_wb_q;
    rdata_d   = rdata_q;
    alu_wb_d  = alu_wb_q;
    pc4_wb_d  = pc4_wb_q;
    misal_d   = misal_q | misal;
    tout_d    = tout_q | timed_out;
    if (stall) begin
      ctrl_wb_d = '0;
    end else begin
      ctrl_wb_d = {ctrl_mem[CTRL_REG_WRITE] & ~misal,
                   ctrl_mem[CTRL_WB_PC4],
                   ctrl_mem[CTRL_MEM_TO_REG]};
      rd_wb_d   = rd_mem[4:0];
      alu_wb_d  = alu_result;
      pc4_wb_d  = pc4_mem;
      rdata_d   = (done & ~timed_out) ? dmem_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_wb_q <= '0;
      rd_wb_q   <= '0;
      rdata_q   <= '0;
      alu_wb_q  <= '0;
      pc4_wb_q  <= '0;
      misal_q   <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      ctrl_wb_q <= ctrl_wb_d;
      rd_wb_q   <= rd_wb_d;
      rdata_q   <= rdata_d;
      alu_wb_q  <= alu_wb_d;
      pc4_wb_q  <= pc4_wb_d;
      misal_q   <= misal_d;
      tout_q    <= tout_d;
    end
  end

  assign ctrl_wb       = ctrl_wb_q;
  assign rd_wb         = rd_wb_q;
  assign read_data     = rdata_q;
  assign alu_result_wb = alu_wb_q;
  assign pc4_wb        = pc4_wb_q;
  assign misaligned    = misal_q;
  assign timeout_err   = tout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level
// model checked every cycle at the falling edge.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, stall;
  logic [2:0]  ctrl_wb;
  logic [4:0]  rd_wb;
  logic [31:0] read_data, alu_result_wb, pc4_wb;
  logic        misaligned, timeout_err;

  mem_stage #(.TIMEOUT(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl_mem     (ctrl_mem),
    .rd_mem       (rd_mem),
    .alu_result   (alu_result),
    .write_data1  (write_data1),
    .pc4_mem      (pc4_mem),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .ctrl_wb      (ctrl_wb),
    .rd_wb        (rd_wb),
    .read_data    (read_data),
    .alu_result_wb(alu_result_wb),
    .pc4_wb       (pc4_wb),
    .misaligned   (misaligned),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_stall = 0;
  bit chk_en = 1'b0;

  // model: expected comb outputs and MEM/WB contents
  logic        e_req = 0, e_stall = 0, e_we = 0;
  logic [31:0] e_addr = 0, e_wd = 0;
  logic [2:0]  m_ctrl = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_rdata = 0, m_alu = 0, m_pc4 = 0;
  logic        m_mis = 0, m_to = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", 32'(dmem_req), 32'(e_req));
      chk("stall", 32'(stall), 32'(e_stall));
      if (e_req) begin
        chk("we", 32'(dmem_we), 32'(e_we));
        chk("addr", dmem_addr, e_addr);
        chk("wdata", dmem_wdata, e_wd);
      end
      chk("ctrl_wb", 32'(ctrl_wb), 32'(m_ctrl));
      chk("rd_wb", 32'(rd_wb), 32'(m_rd));
      chk("read_data", read_data, m_rdata);
      chk("alu_wb", alu_result_wb, m_alu);
      chk("pc4_wb", pc4_wb, m_pc4);
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
      if (stall) n_stall++;
    end
  end

  // One instruction held in EX/MEM until it leaves the stage.
  // ack_at: request cycle index that gets ack (-1 = never).
  task automatic run_op(input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] p4,
                        input logic [31:0] rdv, input int ack_at,
                        input logic [31:0] rdat);
    logic memop, mis, acked, forced, fin;
    for (int k = 0; k < T + 2; k++) begin
      ctrl_mem    = c;
      alu_result  = a;
      write_data1 = wd;
      pc4_mem     = p4;
      rd_mem      = rdv;
      dmem_ack    = (k == ack_at);
      dmem_rdata  = (k == ack_at) ? rdat : 32'hBAD0_0000 + 32'(k);
      memop  = c[0] | c[1];
      mis    = memop && (a[1:0] != 2'b00);
      acked  = memop && !mis && (k == ack_at);
      forced = memop && !mis && !acked && (k == T - 1);
      fin    = !(memop && !mis) || acked || forced;
      e_req   = memop && !mis;
      e_stall = !fin;
      e_we    = c[1];
      e_addr  = a;
      e_wd    = wd;
      @(posedge clk);
      #1;
      if (!fin) begin
        m_ctrl = 3'b000;
      end else begin
        m_ctrl  = {c[4] & !mis, c[3], c[2]};
        m_rd    = rdv[4:0];
        m_alu   = a;
        m_pc4   = p4;
        m_rdata = acked ? rdat : 32'h0;
      end
      m_mis = m_mis | mis;
      m_to  = m_to | forced;
      if (fin) break;
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    ctrl_mem    = '0;
    rd_mem      = '0;
    alu_result  = '0;
    write_data1 = '0;
    pc4_mem     = '0;
    dmem_rdata  = '0;
    dmem_ack    = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst ctrl_wb", 32'(ctrl_wb), 32'h0);
    chk("rst read_data", read_data, 32'h0);
    chk("rst pc4_wb", pc4_wb, 32'h0);
    chk("rst flags", 32'({misaligned, timeout_err}), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // zero-wait load
    run_op(5'b10101, 32'h100, 32'h0, 32'h104, 32'd3, 0, 32'hDEADBEEF);
    chk("ld0 read_data", read_data, 32'hDEADBEEF);
    chk("ld0 ctrl_wb", 32'(ctrl_wb), 32'h5);

    // store acked after 3 extra cycles
    n_stall = 0;
    run_op(5'b00010, 32'h40, 32'h12345678, 32'h108, 32'd0, 3, 32'h0);
    chk("st3 stall cycles", 32'(n_stall), 32'd3);

    // load that times out, then a late ack
    n_stall = 0;
    run_op(5'b10101, 32'h200, 32'h0, 32'h10C, 32'd7, -1, 32'h0);
    chk("to stall cycles", 32'(n_stall), 32'd3);
    chk("to timeout_err", 32'(timeout_err), 32'h1);
    chk("to read_data", read_data, 32'h0);
    run_op(5'b00000, 32'h0, 32'h0, 32'h110, 32'd0, 0, 32'hFFFFFFFF);
    chk("late ack read_data", read_data, 32'h0);

    // misaligned load
    n_stall = 0;
    run_op(5'b10101, 32'h102, 32'h0, 32'h114, 32'd9, 0, 32'h55AA55AA);
    chk("mis flag", 32'(misaligned), 32'h1);
    chk("mis reg_write", 32'(ctrl_wb[2]), 32'h0);
    chk("mis no stall", 32'(n_stall), 32'd0);

    // JAL link write
    run_op(5'b11000, 32'h3000, 32'h0, 32'h2004, 32'd5, -1, 32'h0);
    chk("jal pc4_wb", pc4_wb, 32'h2004);
    chk("jal rd_wb", 32'(rd_wb), 32'd5);
    chk("jal ctrl_wb", 32'(ctrl_wb), 32'h6);

    // back-to-back mix, read+write treated as store
    run_op(5'b10101, 32'h104, 32'h0, 32'h118, 32'd1, 1, 32'h01020304);
    run_op(5'b10101, 32'h108, 32'h0, 32'h11C, 32'd2, 0, 32'hA5A5A5A5);
    run_op(5'b00011, 32'h80, 32'hCCDD0011, 32'h120, 32'd0, 0, 32'h0);
    run_op(5'b10000, 32'h55, 32'h0, 32'h124, 32'd4, -1, 32'h0);
    run_op(5'b00010, 32'h41, 32'h99, 32'h128, 32'd0, 0, 32'h0);

    // reset while waiting
    chk_en = 1'b0;
    ctrl_mem   = 5'b10101;
    alu_result = 32'h300;
    rd_mem     = 32'd6;
    dmem_ack   = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2 req", 32'(dmem_req), 32'h0);
    chk("rst2 stall", 32'(stall), 32'h0);
    chk("rst2 ctrl_wb", 32'(ctrl_wb), 32'h0);
    chk("rst2 read_data", read_data, 32'h0);
    chk("rst2 alu_wb", alu_result_wb, 32'h0);
    chk("rst2 flags", 32'({misaligned, timeout_err}), 32'h0);
    ctrl_mem = 5'b00000;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_ctrl = 0; m_rd = 0; m_rdata = 0; m_alu = 0; m_pc4 = 0;
    m_mis = 0; m_to = 0;
    e_req = 0; e_stall = 0;
    chk_en = 1'b1;
    run_op(5'b10101, 32'h300, 32'h0, 32'h130, 32'd6, 2, 32'hCAFEF00D);
    chk("post rst read_data", read_data, 32'hCAFEF00D);
    chk("post rst timeout", 32'(timeout_err), 32'h0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32 pipeline, between the EX/MEM pipeline register and write-back. Consumes the EX stage's registered outputs, runs word loads/stores over a variable-latency request/acknowledge data-memory port, raises a pipeline stall while an access is outstanding, and drives the MEM/WB pipeline register. It also detects misaligned accesses and flags accesses that time out.

## Interface
- `TIMEOUT`, default 16: maximum cycles an access may wait for `dmem_ack` before forced completion (≥2).
- `clk` in 1: pipeline clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctrl_mem` in 5: [0] mem_read, [1] mem_write, [2] mem_to_reg, [3] wb_pc4 (JAL link), [4] reg_write.
- `rd_mem` in 32: destination register; only [4:0] used.
- `alu_result` in 32: effective address or ALU result.
- `write_data1` in 32: store data.
- `pc4_mem` in 32: PC+4 of the instruction.
- `dmem_req` out 1: access request (combinational).
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 32: `alu_result`.
- `dmem_wdata` out 32: `write_data1`.
- `dmem_rdata` in 32: load data, valid in the `dmem_ack` cycle.
- `dmem_ack` in 1: access complete this cycle.
- `stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM (combinational).
- `ctrl_wb` out 3: registered {reg_write, wb_pc4, mem_to_reg}.
- `rd_wb` out 5, `read_data` out 32, `alu_result_wb` out 32, `pc4_wb` out 32: registered MEM/WB fields.
- `misaligned` out 1: sticky; set by any access with `alu_result[1:0] != 0`.
- `timeout_err` out 1: sticky; set on forced completion.

## Operation
- An instruction is a memory op if mem_read or mem_write is set. Both set: treat as store.
- Misaligned op: no request issued. `misaligned` is set, the op completes this cycle with no stall, `read_data` = 0, and reg_write is suppressed in `ctrl_wb`.
- FSM states: IDLE, WAIT.
  - IDLE with an aligned memory op: `dmem_req`=1, `stall`=!`dmem_ack`. Ack → complete and stay IDLE. No ack → WAIT, and `wait_cnt` is set to 1.
  - WAIT: `dmem_req`=1 and `stall`=1 unless completing.
    - Ack → complete, go to IDLE.
    - Otherwise, if `wait_cnt` == TIMEOUT−1 → forced completion: `timeout_err` is set, `read_data` = 0, `stall`=0, go to IDLE.
    - Otherwise `wait_cnt` increments.
- `dmem_we`, `dmem_addr` and `dmem_wdata` must stay stable while `dmem_req` is high. This holds because `stall` freezes EX/MEM.
- `dmem_ack` while `dmem_req`=0 is ignored, including a late ack after a timeout.
- Non-memory op: no request, no stall, passes straight through.
- MEM/WB register:
  - On a non-stall cycle it loads `ctrl_wb`, `rd_mem[4:0]`, `alu_result`, `pc4_mem`, and `read_data` (`dmem_rdata` on ack, else 0).
  - On a stall cycle it loads a bubble: `ctrl_wb` = 0, all other fields hold.
- Stores write reg_write=0 as decoded; the stage does not force it.

## Timing
- Reset: every registered output, `misaligned`, `timeout_err` and `wait_cnt` = 0, FSM = IDLE. Reset mid-access abandons it, with `dmem_req` low during reset.
- Zero-wait memory (ack in the request cycle): 1-cycle latency, no stall, result in MEM/WB at the next edge.
- Ack after N extra cycles: `stall` high for N cycles, result registered on the edge after the ack cycle.
- Timeout: `stall` is high for exactly TIMEOUT−1 cycles; completion happens in the TIMEOUT-th request cycle.
- The upstream instruction advances on the edge after `stall` drops; back-to-back memory ops issue on consecutive cycles with no idle gap.

## Structure
- Shared package `riscv_pkg` holds:
  - control bit indices: `CTRL_MEM_READ`, `CTRL_MEM_WRITE`, `CTRL_MEM_TO_REG`, `CTRL_WB_PC4`, `CTRL_REG_WRITE`;
  - `CTRL_WB_W` = 3;
  - the FSM state enum `mem_state_t`.
- Sub-module `dmem_handshake`: FSM, `wait_cnt`, timeout detect. Outputs `dmem_req`, `stall`, `done`, `timed_out`.
- `mem_stage` holds the misalignment check, sticky flags and the MEM/WB register.

## Test plan
- Load, addr 0x100, ack same cycle with rdata 0xDEADBEEF, ctrl_mem 5'b10101 → no stall; next edge `read_data`=0xDEADBEEF, `ctrl_wb`=3'b101.
- Store, addr 0x40, wdata 0x12345678, ack after 3 cycles → `stall` high 3 cycles; `dmem_we`/addr/wdata stable throughout; bubble (`ctrl_wb`=0) in MEM/WB during the stall.
- Load never acked, TIMEOUT=4 → `stall` high 3 cycles, `timeout_err`=1, `read_data`=0; a late ack is ignored.
- Load at addr 0x102 → `dmem_req` never high, `misaligned`=1, `ctrl_wb[2]`=0, no stall.
- JAL-type, ctrl_mem 5'b11000, pc4 0x2004, rd 5 → no request; `pc4_wb`=0x2004, `rd_wb`=5, `ctrl_wb`=3'b110.
- `reset_n` asserted while in WAIT → `dmem_req` and `stall` immediately 0, all outputs 0, FSM IDLE.
